// File: rtl/wb_serial_streamer.sv
// wb_serial_streamer: Wishbone classic slave that streams START+k*STEP words serially after a CTRL write
// Ports: CLK_I/RST_I clock and sync active-high reset; CYC_I STB_I WE_I ADR_I DAT_I DAT_O ACK_O
// Wishbone classic slave (CTRL @0x0, STAT @0x4); ena_o frame sync; data_o serial data LSB first;
// busy_o stream in progress
module wb_serial_streamer #(
   parameter int WORD_W       = 10,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK_O,
   output logic        ena_o,
   output logic        data_o,
   output logic        busy_o
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(WORD_W + 1);
   typedef enum logic [1:0] {IDLE, SYNC, SHIFT, DONE} state_t;
   state_t state, state_n;
   logic [31:0] ctrl, rdata;
   logic [WORD_W-1:0] acc;
   logic [7:0] words;
   logic [CW-1:0] clk_cnt;
   logic [BW-1:0] bit_cnt;
   logic hold, req, is_ctrl, accept, ctrl_wr, start, bit_end, word_end, ena_d, data_d;
   logic unused;
   assign unused   = ^{ADR_I[31:4], ADR_I[1:0]};
   assign req      = CYC_I & STB_I;
   assign is_ctrl  = ADR_I[3:2] == 2'd0;
   // CTRL writes stall (no ack) until the FSM is back in IDLE
   assign accept   = req & ~hold & ~(WE_I & is_ctrl & (state != IDLE));
   assign ctrl_wr  = accept & WE_I & is_ctrl;
   assign start    = ctrl_wr & (DAT_I[23:16] != 8'd0);
   assign bit_end  = clk_cnt == CW'(CLKS_PER_BIT - 1);
   assign word_end = bit_end & (bit_cnt == BW'(WORD_W - 1));
   assign rdata    = is_ctrl ? ctrl : (ADR_I[3:2] == 2'd1) ? {busy_o, 23'd0, words} : 32'd0;
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ACK_O <= 1'b0;
         DAT_O <= '0;
         hold  <= 1'b0;
         ctrl  <= '0;
      end else begin
         ACK_O <= accept;
         // suppress re-acks while the master keeps the same strobe asserted
         hold  <= req & (hold | accept);
         DAT_O <= (accept & ~WE_I) ? rdata : '0;
         if (ctrl_wr) ctrl <= DAT_I;
      end
   end
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         words   <= '0;
         acc     <= '0;
      end else begin
         state   <= state_n;
         clk_cnt <= (state == IDLE || state == DONE || bit_end) ? '0 : clk_cnt + 1'b1;
         bit_cnt <= (state != SHIFT || word_end) ? '0 : bit_end ? bit_cnt + 1'b1 : bit_cnt;
         if (ctrl_wr) begin
            words <= DAT_I[23:16];
            acc   <= WORD_W'(DAT_I[7:0]);
         end else if (state == SHIFT && word_end) begin
            words <= words - 8'd1;
            acc   <= acc + WORD_W'(ctrl[15:8]);
         end
      end
   end
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  state_n = start ? SYNC : IDLE;
         SYNC:  state_n = bit_end ? SHIFT : SYNC;
         SHIFT: state_n = (word_end && words == 8'd1) ? DONE : SHIFT;
         DONE:  state_n = IDLE;
      endcase
   end
   // outputs are registered one cycle behind the state they decode
   always_comb begin
      ena_d  = state == SYNC;
      data_d = (state == SHIFT) & acc[bit_cnt];
   end
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ena_o  <= 1'b0;
         data_o <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         ena_o  <= ena_d;
         data_o <= data_d;
         busy_o <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_wb_serial_streamer.sv
// tb_wb_serial_streamer: self-checking bench for wb_serial_streamer
module tb_wb_serial_streamer;
   logic CLK_I = 0, RST_I = 1, CYC_I = 0, STB_I = 0, WE_I = 0;
   logic [31:0] ADR_I = 0, DAT_I = 0, DAT_O;
   logic ACK_O, ena_o, data_o, busy_o;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit chk_en = 0;
   typedef struct {int a; int st; int sp; int n;} strm_t;
   strm_t streams[$];
   logic [9:0] cap_q[$];
   logic [9:0] cap_w = 0;
   logic [31:0] m_ctrl = 0;
   logic [4:0] e;
   wb_serial_streamer dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
      .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
      .ena_o(ena_o), .data_o(data_o), .busy_o(busy_o)
   );
   always #5 CLK_I = ~CLK_I;
   always @(posedge CLK_I) cyc <= cyc + 1;
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask
   function automatic logic [9:0] word_of(input int st, input int sp, input int k);
      return 10'((st + k * sp) % 1024);
   endfunction
   // {word_done, capture, ena, data, busy} expected in cycle c
   function automatic logic [4:0] exp_out(input int c);
      logic [4:0] r;
      logic [9:0] w;
      int a, last, off;
      r = 0;
      foreach (streams[i]) begin
         a = streams[i].a;
         last = a + 4 + 40 * streams[i].n;
         if (c >= a && c <= last) r[0] = 1;
         if (c >= a + 1 && c <= a + 4) r[2] = 1;
         if (c >= a + 5 && c <= last) begin
            off = c - a - 5;
            w = word_of(streams[i].st, streams[i].sp, off / 40);
            r[1] = w[(off % 40) / 4];
            r[3] = (off % 4) == 2;
            r[4] = r[3] && ((off % 40) / 4) == 9;
         end
      end
      return r;
   endfunction
   function automatic int idle_from();
      return streams.size() == 0 ? 0 : streams[$].a + 5 + 40 * streams[$].n;
   endfunction
   function automatic logic [31:0] stat_at(input int s);
      int a;
      foreach (streams[i]) begin
         a = streams[i].a;
         if (s >= a && s <= a + 4 + 40 * streams[i].n)
            return {1'b1, 23'd0, 8'(s < a + 4 ? streams[i].n : streams[i].n - (s - a - 4) / 40)};
      end
      return 0;
   endfunction
   always @(negedge CLK_I) if (chk_en) begin
      e = exp_out(cyc);
      check($sformatf("out@%0d", cyc), {29'd0, ena_o, data_o, busy_o}, {29'd0, e[2:0]});
      if (e[3]) cap_w = {data_o, cap_w[9:1]};
      if (e[4]) cap_q.push_back(cap_w);
   end
   task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] dat, input int hold,
                     output logic [31:0] rd);
      int s, a, n, acks;
      logic [31:0] exp_rd;
      @(posedge CLK_I); #1;
      CYC_I = 1; STB_I = 1; WE_I = we; ADR_I = adr; DAT_I = dat;
      s = cyc;
      a = (we && adr[3:2] == 0) ? ((s > idle_from() ? s : idle_from()) + 1) : s + 1;
      exp_rd = we ? 0 : adr[3:2] == 0 ? m_ctrl : adr[3:2] == 1 ? stat_at(s) : 0;
      if (we && adr[3:2] == 0 && dat[23:16] != 0)
         streams.push_back('{a, int'(dat[7:0]), int'(dat[15:8]), int'(dat[23:16])});
      n = 0;
      do begin @(negedge CLK_I); n++; end while (!ACK_O && n < 3000);
      rd = DAT_O;
      if (!ACK_O) check("ack_timeout", 0, 1);
      else begin
         check("ack_cycle", 32'(cyc), 32'(a));
         check("dat_o", DAT_O, exp_rd);
      end
      acks = ACK_O ? 1 : 0;
      repeat (hold) begin @(negedge CLK_I); acks += int'(ACK_O); end
      check("ack_count", 32'(acks), 1);
      @(posedge CLK_I); #1;
      CYC_I = 0; STB_I = 0; WE_I = 0;
      if (we && adr[3:2] == 0) m_ctrl = dat;
   endtask
   task automatic wait_idle();
      while (cyc < idle_from() + 2) @(posedge CLK_I);
   endtask
   initial begin
      logic [31:0] rd;
      logic [9:0] exp1[6] = '{10'h001, 10'h003, 10'h005, 10'h001, 10'h003, 10'h005};
      logic [9:0] exp2[5] = '{10'h0FF, 10'h1FE, 10'h2FD, 10'h3FC, 10'h0FB};
      repeat (2) @(posedge CLK_I);
      #1; RST_I = 0; chk_en = 1;
      repeat (200) @(posedge CLK_I);
      wb(0, 32'h4, 0, 0, rd);
      check("stat_idle", rd, 32'h0);
      wb(0, 32'h0, 0, 0, rd);
      check("ctrl_rst", rd, 32'h0);
      cap_q.delete();
      wb(1, 32'h0, 32'h0003_0201, 0, rd);
      repeat (50) @(posedge CLK_I);
      wb(0, 32'h4, 0, 0, rd);
      check("stat_mid", rd, 32'h8000_0002);
      wb(1, 32'h0, 32'h0003_0201, 3, rd);
      wait_idle();
      check("cap1_n", 32'(cap_q.size()), 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++) check($sformatf("cap1_%0d", i), 32'(cap_q[i]), 32'(exp1[i]));
      cap_q.delete();
      wb(1, 32'h0, 32'h0005_FFFF, 0, rd);
      wait_idle();
      check("cap2_n", 32'(cap_q.size()), 5);
      for (int i = 0; i < 5 && i < cap_q.size(); i++) check($sformatf("cap2_%0d", i), 32'(cap_q[i]), 32'(exp2[i]));
      wb(1, 32'h0, 32'h0000_0A07, 1, rd);
      repeat (20) @(posedge CLK_I);
      wb(0, 32'h0, 0, 0, rd);
      check("ctrl_rb", rd, 32'h0000_0A07);
      wb(1, 32'h8, 32'hDEAD_BEEF, 0, rd);
      wb(0, 32'h8, 0, 0, rd);
      check("rd_8", rd, 32'h0);
      wb(0, 32'hC, 0, 0, rd);
      wb(0, 32'h4, 0, 0, rd);
      check("stat_cnt0", rd, 32'h0);
      wb(1, 32'h0, 32'h0002_0305, 0, rd);
      repeat (30) @(posedge CLK_I);
      #1; RST_I = 1;
      @(posedge CLK_I); #1;
      streams.delete(); m_ctrl = 0; RST_I = 0;
      repeat (3) @(posedge CLK_I);
      wb(0, 32'h4, 0, 0, rd);
      check("stat_rst", rd, 32'h0);
      cap_q.delete();
      wb(1, 32'h0, 32'h0001_0102, 0, rd);
      wait_idle();
      check("cap3_n", 32'(cap_q.size()), 1);
      if (cap_q.size() > 0) check("cap3_0", 32'(cap_q[0]), 32'h002);
      repeat (10) @(posedge CLK_I);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
